// File: rtl/lsu_pkg.sv
// Shared types and RV32I load/store funct3 encodings for the load/store unit.
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, RESP} lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/lsu_align.sv
// Byte/half lane handling: formats sub-word loads and merges sub-word store
// data into a word read back from RAM.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_wdata
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase

        // Untouched lanes keep the word read back from RAM.
        merged_wdata = rdata;
        case (funct3)
            F3_B: merged_wdata[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) merged_wdata[31:16] = wdata[15:0];
                else         merged_wdata[15:0]  = wdata[15:0];
            end
            F3_W:    merged_wdata = wdata;
            default: merged_wdata = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed single-cycle RAM; sub-word
// stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    lsu_state_e  state, state_nx;
    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, rd_q;
    logic        accept, misalign, out_of_range, bad_f3, err;
    logic [31:0] align_rdata, load_data, merged_wdata;

    assign accept    = req_valid && req_ready;
    assign req_ready = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        misalign     = ((a_f3 == F3_H || a_f3 == F3_HU) && a_addr[0]) ||
                       (a_f3 == F3_W && a_addr[1:0] != 2'b00);
        out_of_range = (a_addr >> (MEM_DEPTH_LOG2 + 2)) != '0;
        bad_f3       = a_we ? !(a_f3 inside {F3_B, F3_H, F3_W})
                            : !(a_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        err          = misalign || out_of_range || bad_f3;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = CHECK;
            CHECK: begin
                if (err)                                  state_nx = RESP;
                else if (a_we && a_f3 == F3_W)            state_nx = WRITE;
                else                                      state_nx = READ;
            end
            READ:  state_nx = a_we ? WRITE : RESP;
            WRITE: state_nx = RESP;
            RESP:  if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_we       <= 1'b0;
            a_f3       <= '0;
            a_addr     <= '0;
            a_wdata    <= '0;
            rd_q       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_we       <= req_we;
                a_f3       <= req_funct3;
                a_addr     <= req_addr;
                a_wdata    <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
            if (state == CHECK && err) resp_err <= 1'b1;
            if (state == READ) begin
                rd_q <= mem_rdata;
                if (!a_we) resp_rdata <= load_data;
            end
        end
    end

    // READ formats straight off the RAM; WRITE merges into the captured word.
    assign align_rdata = (state == WRITE) ? rd_q : mem_rdata;

    lsu_align u_align (
        .funct3       (a_f3),
        .lane         (a_addr[1:0]),
        .rdata        (align_rdata),
        .wdata        (a_wdata),
        .load_data    (load_data),
        .merged_wdata (merged_wdata)
    );

    assign mem_address      = (state == IDLE) ? '0
                            : {{(32 - MEM_DEPTH_LOG2){1'b0}}, a_addr[MEM_DEPTH_LOG2+1:2]};
    assign mem_write_enable = (state == WRITE) && !rst;
    assign mem_wdata        = mem_write_enable ? merged_wdata : '0;
endmodule
